// File: rtl/vga_frame_capture_if.sv
// Frame-capture bus: incoming VGA video, capture control and
// the single frame-buffer write port.
interface vga_frame_capture_if #(
  parameter int AW = 19
);
  logic          hs;
  logic          vs;
  logic [11:0]   rgb;
  logic          cap_req;
  logic          we;
  logic [AW-1:0] waddr;
  logic [11:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output hs, vs, rgb, cap_req,
    input  we, waddr, wdata, busy, done, err
  );

  modport slave (
    input  hs, vs, rgb, cap_req,
    output we, waddr, wdata, busy, done, err
  );
endinterface

// File: rtl/vga_frame_capture.sv
// Grabs one full active VGA frame per request and writes it
// linearly into the frame buffer, aborting on sync timing errors.
module vga_frame_capture #(
  parameter int H_BP  = 64,
  parameter int H_ACT = 800,
  parameter int H_TOT = 1040,
  parameter int V_BP  = 23,
  parameter int V_ACT = 600,
  parameter int AW    = 19
) (
  input logic              pclk,
  input logic              rstn,
  vga_frame_capture_if.slave io_cap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_VBP,
    S_ACT,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(H_ACT * V_ACT - 1);
  localparam logic [10:0] HC_LO  = 11'(H_BP);
  localparam logic [10:0] HC_HI  = 11'(H_BP + H_ACT - 1);
  localparam logic [10:0] HC_END = 11'(H_TOT - 1);

  state_t r_state;
  state_t w_nxt;

  logic          r_hs_q;
  logic          r_hs_qq;
  logic          r_vs_q;
  logic          r_vs_qq;
  logic [11:0]   r_rgb_q;
  logic [11:0]   r_rgb_qq;
  logic [10:0]   r_hcnt;
  logic [10:0]   r_lcnt;
  logic [AW-1:0] r_wptr;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [11:0]   r_wdata;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic w_hs_fall;
  logic w_vs_fall;
  logic w_in_act;
  logic w_last;
  logic w_chk;
  logic w_viol;
  logic w_wr;

  assign w_hs_fall = r_hs_qq & ~r_hs_q;
  assign w_vs_fall = r_vs_qq & ~r_vs_q;
  assign w_in_act  = (r_hcnt >= HC_LO) && (r_hcnt <= HC_HI);
  assign w_last    = r_we && (r_waddr == LAST);
  assign w_chk     = (r_state == S_VBP) || (r_state == S_ACT);

  // the completed final write wins over a coincident sync edge
  assign w_viol = w_chk && !w_last &&
                  ((w_hs_fall && (r_hcnt != HC_END)) || w_vs_fall);

  // rgb_qq lines up with hcnt: pixel p after hs fall has hcnt == p
  assign w_wr = (r_state == S_ACT) && w_in_act && !w_viol && !w_last;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (io_cap.cap_req) w_nxt = S_ARM;
      S_ARM:  if (w_vs_fall) w_nxt = S_VBP;
      S_VBP: begin
        if (w_viol)
          w_nxt = S_DONE;
        else if (w_hs_fall && (r_lcnt == 11'(V_BP)))
          w_nxt = S_ACT;
      end
      S_ACT:  if (w_last || w_viol) w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_hs_q   <= 1'b0;
      r_hs_qq  <= 1'b0;
      r_vs_q   <= 1'b0;
      r_vs_qq  <= 1'b0;
      r_rgb_q  <= '0;
      r_rgb_qq <= '0;
      r_hcnt   <= '0;
      r_lcnt   <= '0;
      r_wptr   <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_hs_q   <= io_cap.hs;
      r_hs_qq  <= r_hs_q;
      r_vs_q   <= io_cap.vs;
      r_vs_qq  <= r_vs_q;
      r_rgb_q  <= io_cap.rgb;
      r_rgb_qq <= r_rgb_q;

      if (w_hs_fall)
        r_hcnt <= '0;
      else if (r_hcnt != 11'h7ff)
        r_hcnt <= r_hcnt + 11'd1;

      r_state <= w_nxt;

      if (r_state == S_ARM)
        r_lcnt <= '0;
      else if ((r_state == S_VBP) && w_hs_fall)
        r_lcnt <= r_lcnt + 11'd1;

      if (r_state == S_ARM)
        r_wptr <= '0;
      else if (w_wr)
        r_wptr <= r_wptr + AW'(1);

      r_we <= w_wr;
      if (w_wr) begin
        r_waddr <= r_wptr;
        r_wdata <= r_rgb_qq;
      end

      r_busy <= (w_nxt == S_ARM) || (w_nxt == S_VBP) ||
                (w_nxt == S_ACT);
      r_done <= (w_nxt == S_DONE);

      if ((r_state == S_IDLE) && io_cap.cap_req)
        r_err <= 1'b0;
      else if (w_viol)
        r_err <= 1'b1;
    end
  end

  assign io_cap.we    = r_we;
  assign io_cap.waddr = r_waddr;
  assign io_cap.wdata = r_wdata;
  assign io_cap.busy  = r_busy;
  assign io_cap.done  = r_done;
  assign io_cap.err   = r_err;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a scaled-down video timing,
// with a pixel-level write model fed by the stream generator.
module tb_vga_frame_capture;

  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 8;
  localparam int HT = 17;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VA = 4;
  localparam int VT = 10;
  localparam int NP = HA * VA;
  localparam int FR = HT * VT;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic pclk = 1'b0;
  logic rstn = 1'b0;

  always #5 pclk = ~pclk;

  vga_frame_capture_if #(.AW(19)) cap_if ();

  vga_frame_capture #(
    .H_BP (HB),
    .H_ACT(HA),
    .H_TOT(HT),
    .V_BP (VB),
    .V_ACT(VA),
    .AW   (19)
  ) dut (
    .pclk  (pclk),
    .rstn  (rstn),
    .io_cap(cap_if)
  );

  wr_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int gf = 0;
  int gy = 0;
  int gx = 0;
  int cap_frame = -1;
  int short_row = -1;
  int ev_row = -1;
  bit aborted = 1'b0;
  bit exp_err = 1'b0;
  bit pat = 1'b1;
  int wr_cnt = 0;
  int done_cnt = 0;
  int last_addr = -1;
  int last_wr_cyc = -100;
  int d_at0 = -1;
  int d_at9 = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // video source; also predicts every write of the captured frame
  initial begin
    cap_if.hs = 1'b0;
    cap_if.vs = 1'b0;
    cap_if.rgb = '0;
    cap_if.cap_req = 1'b0;
    forever begin
      aborted = 1'b0;
      for (int y = 0; y < VT; y++) begin
        int row;
        int len;
        bit capf;
        row = y - VS - VB;
        capf = (gf == cap_frame);
        len = (capf && short_row >= 0 && row == short_row) ? HT - 1 : HT;
        if (capf && ((ev_row >= 0 && row == ev_row) ||
                     (short_row >= 0 && row == short_row + 1))) begin
          aborted = 1'b1;
          exp_err = 1'b1;
        end
        for (int x = 0; x < len; x++) begin
          int col;
          bit act;
          logic [11:0] pix;
          @(negedge pclk);
          col = x - HS - HB;
          act = row >= 0 && row < VA && col >= 0 && col < HA;
          gy = y;
          gx = x;
          pix = 12'($urandom);
          if (pat && act) pix = {6'(row), 6'(col)};
          cap_if.hs = (x < HS);
          cap_if.vs = (y < VS) ||
                      (capf && ev_row >= 0 && row == ev_row && x < 2);
          cap_if.rgb = pix;
          if (act && capf && !aborted)
            exp_q.push_back('{row * HA + col, int'(pix), cyc + 3});
        end
      end
      gf++;
    end
  end

  // single compare process, one check set per cycle
  initial begin
    forever begin
      @(posedge pclk);
      #1;
      cyc++;
      if (!rstn) begin
        exp_q.delete();
        chk("rst_we", cap_if.we, 0);
        chk("rst_waddr", cap_if.waddr, 0);
        chk("rst_wdata", cap_if.wdata, 0);
        chk("rst_busy", cap_if.busy, 0);
        chk("rst_done", cap_if.done, 0);
        chk("rst_err", cap_if.err, 0);
      end else begin
        bit ew;
        ew = exp_q.size() > 0 && exp_q[0].cyc == cyc;
        chk("we", cap_if.we, ew);
        if (cap_if.we) begin
          wr_cnt++;
          last_addr = int'(cap_if.waddr);
          if (cap_if.waddr == 0) d_at0 = int'(cap_if.wdata);
          if (cap_if.waddr == 9) d_at9 = int'(cap_if.wdata);
          if (cap_if.waddr == NP - 1) last_wr_cyc = cyc;
        end
        if (ew) begin
          chk("waddr", cap_if.waddr, exp_q[0].addr);
          chk("wdata", cap_if.wdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        if (cap_if.done) begin
          done_cnt++;
          chk("busy_at_done", cap_if.busy, 0);
          chk("err_at_done", cap_if.err, exp_err);
          if (!exp_err) chk("done_lat", cyc, last_wr_cyc + 1);
        end
      end
    end
  end

  task automatic wait_pos(input int y, input int x);
    int i;
    for (i = 0; i < 4 * FR && !(gy == y && gx == x); i++)
      @(negedge pclk);
    chk("pos_timeout", i < 4 * FR, 1);
  endtask

  task automatic req(input bit accept);
    if (accept) begin
      cap_frame = gf + 1;
      exp_err = 1'b0;
    end
    cap_if.cap_req = 1'b1;
    @(negedge pclk);
    cap_if.cap_req = 1'b0;
    chk("busy_rise", cap_if.busy, 1);
    if (accept) chk("err_clr", cap_if.err, 0);
  endtask

  task automatic wait_done(input string nm);
    int d0;
    int i;
    d0 = done_cnt;
    for (i = 0; i < 4 * FR && done_cnt == d0; i++)
      @(negedge pclk);
    chk(nm, done_cnt - d0, 1);
  endtask

  initial begin
    int w0;
    int d0;
    int i;
    rstn = 1'b0;
    repeat (4) @(negedge pclk);
    rstn = 1'b1;
    repeat (3) @(negedge pclk);

    pat = 1'b1;
    wait_pos(VT - 1, 3);
    w0 = wr_cnt;
    req(1'b1);
    wait_done("nom_done");
    chk("nom_writes", wr_cnt - w0, NP);
    chk("nom_err", cap_if.err, 0);
    chk("nom_busy", cap_if.busy, 0);
    chk("nom_d9", d_at9, 12'h041);
    chk("nom_d0", d_at0, 0);

    pat = 1'b0;
    wait_pos(VS + VB + 2, 5);
    w0 = wr_cnt;
    req(1'b1);
    wait_done("mid_done");
    chk("mid_writes", wr_cnt - w0, NP);
    chk("mid_err", cap_if.err, 0);

    wait_pos(VT - 1, 3);
    w0 = wr_cnt;
    d0 = done_cnt;
    req(1'b1);
    wait_pos(VS + VB + 1, 5);
    req(1'b0);
    wait_done("ign_done");
    repeat (2 * FR) @(negedge pclk);
    chk("ign_single_done", done_cnt - d0, 1);
    chk("ign_writes", wr_cnt - w0, NP);
    chk("ign_idle", cap_if.busy, 0);

    short_row = 2;
    wait_pos(VT - 1, 3);
    w0 = wr_cnt;
    req(1'b1);
    wait_done("short_done");
    short_row = -1;
    chk("short_writes", wr_cnt - w0, 3 * HA);
    chk("short_err", cap_if.err, 1);
    chk("short_busy", cap_if.busy, 0);
    wait_pos(VT - 1, 3);
    w0 = wr_cnt;
    req(1'b1);
    wait_done("recap_done");
    chk("recap_writes", wr_cnt - w0, NP);
    chk("recap_err", cap_if.err, 0);

    wait_pos(VT - 1, 3);
    req(1'b1);
    for (i = 0; i < 4 * FR &&
         !(cap_if.we && cap_if.waddr == 13); i++)
      @(negedge pclk);
    chk("rst_addr_timeout", i < 4 * FR, 1);
    cap_frame = -1;
    rstn = 1'b0;
    @(negedge pclk);
    rstn = 1'b1;
    chk("rst_mid_busy", cap_if.busy, 0);
    w0 = wr_cnt;
    d0 = done_cnt;
    repeat (2 * FR) @(negedge pclk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_wr", wr_cnt - w0, 0);

    ev_row = 2;
    wait_pos(VT - 1, 3);
    w0 = wr_cnt;
    req(1'b1);
    wait_done("ev_done");
    ev_row = -1;
    chk("ev_writes", wr_cnt - w0, 2 * HA);
    chk("ev_err", cap_if.err, 1);
    chk("ev_last_addr", last_addr < 2 * HA, 1);

    repeat (FR) @(negedge pclk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
